// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding,
// reset constants and the {pc, instr} record carried through the fetch FIFO.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_WAIT = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} records; flush beats push.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem_reg [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Storage is cleared on reset so the head reads as pc 0 / NOP afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '{pc: 32'h0, instr: NOP};
            end
        end else if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one request at a time to
// instruction memory and buffers returned words, discarding wrong-path data.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic [31:0] out_instr
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   req_addr_reg, req_addr_next;
    logic          kill_reg, kill_next;

    logic          fifo_push, fifo_pop, fifo_flush;
    logic [CW-1:0] fifo_count, count_next;
    fetch_entry_t  fifo_head, push_entry;
    logic          space;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .count      (fifo_count),
        .head       (fifo_head)
    );

    always_comb begin
        out_valid  = (fifo_count != '0);
        fifo_flush = redirect_valid;
        fifo_pop   = out_valid && !stall && !redirect_valid;
        fifo_push  = (state_reg == ST_WAIT) && imem_rvalid && !kill_reg;
        push_entry = '{pc: req_addr_reg, instr: imem_rdata};
        count_next = fifo_flush ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        // A new request is only issued when its response is guaranteed a slot.
        space      = count_next < CW'(DEPTH);
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_addr_next = req_addr_reg;
        kill_next     = kill_reg;

        case (state_reg)
            ST_IDLE: begin
                if (!redirect_valid && space) begin
                    state_next    = ST_REQ;
                    req_addr_next = fetch_pc_reg;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_next = ST_WAIT;
                    if (!kill_reg && !redirect_valid) fetch_pc_next = fetch_pc_reg + 32'd4;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    kill_next = 1'b0;
                    if (!redirect_valid && space) begin
                        state_next    = ST_REQ;
                        req_addr_next = fetch_pc_reg;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Redirect never withdraws a request; it only marks its response as dead.
        if (redirect_valid) begin
            fetch_pc_next = word_align(redirect_pc);
            if (state_reg == ST_REQ || (state_reg == ST_WAIT && !imem_rvalid)) kill_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= RESET_PC;
            kill_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_addr_reg <= req_addr_next;
            kill_reg     <= kill_next;
        end
    end

    assign imem_req     = (state_reg == ST_REQ);
    assign imem_addr    = req_addr_reg;
    assign out_pc       = fifo_head.pc;
    assign out_instr    = fifo_head.instr;
    assign out_pc_plus4 = fifo_head.pc + 32'd4;

endmodule
